// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle RV32I control unit: FSM states,
// opcode constants, ALU operation codes and datapath mux selects.
package multicycle_control_unit_pkg;

  localparam int OPC_W    = 7;
  localparam int ALU_OP_W = 3;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_JAL,
    S_BEQ
  } state_t;

  // Opcodes of the supported subset
  localparam logic [OPC_W-1:0] OP_LW    = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_SW    = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_RTYPE = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_ITYPE = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_JAL   = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_BEQ   = 7'b1100011;

  // ALU operation codes, shared with Arithmetic_Logic_Unit
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 3'b111;

  // Result mux
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // ALU operand A mux
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLD_PC = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;

  // ALU operand B mux
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU decoder: maps funct3/funct7b5 of R- and I-type instructions onto the
// ALU operation code. funct7b5 only selects SUB for R-type; SRA is not
// supported, so funct3=101 is always SRL.
module alu_decoder
  import multicycle_control_unit_pkg::*;
(
  input  logic                is_rtype,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  output logic [ALU_OP_W-1:0] alu_op
);

  // Pure combinational funct3 lookup
  always_comb begin
    // NOTE: the default assignment first means every path drives alu_op, so no latch is inferred.
    alu_op = ALU_ADD;
    unique case (funct3)
      3'b000:  alu_op = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_op = ALU_AND;
      3'b110:  alu_op = ALU_OR;
      3'b100:  alu_op = ALU_XOR;
      3'b010:  alu_op = ALU_SLT;
      3'b001:  alu_op = ALU_SLL;
      3'b101:  alu_op = ALU_SRL;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main FSM of the multicycle RV32I core. All outputs are decoded
// combinationally from the current state (plus mem_ready in the stalling
// states and zero in BEQ); only the state itself is registered.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                adr_src,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic [1:0]          result_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          imm_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal
);

  state_t              state;
  state_t              state_next;
  logic [ALU_OP_W-1:0] dec_alu_op;

  alu_decoder u_alu_decoder (
    .is_rtype (opcode == OP_RTYPE),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .alu_op   (dec_alu_op)
  );

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  // Next-state and output decode
  always_comb begin
    state_next = state;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    imm_src    = IMM_I;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;

    unique case (state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        // Speculatively compute the branch target from the old PC
        alu_src_a = SRCA_OLD_PC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
        unique case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC_R;
          OP_ITYPE:     state_next = S_EXEC_I;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        imm_src    = (opcode == OP_SW) ? IMM_S : IMM_I;
        state_next = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = dec_alu_op;
        state_next = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_I;
        alu_op     = dec_alu_op;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        // PC <= branch target from DECODE; ALU forms old PC + 4 for rd
        alu_src_a  = SRCA_OLD_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        imm_src    = IMM_J;
        state_next = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_SUB;
        result_src = RES_ALUOUT;
        pc_write   = zero;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase

    // Drop architectural write strobes while reset is asserted so an
    // interrupted store or writeback never commits.
    if (!rst_n) begin
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class
// through the FSM and compares the full output vector every cycle against
// hand-derived expected patterns.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_op;

  int assert_count = 0;
  int fail_count   = 0;

  multicycle_control_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .imm_src    (imm_src),
    .alu_op     (alu_op),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // {pc_write, adr_src, mem_write, ir_write, reg_write,
  //  result_src, alu_src_a, alu_src_b, imm_src, alu_op, illegal}
  logic [16:0] outs;
  assign outs = {pc_write, adr_src, mem_write, ir_write, reg_write,
                 result_src, alu_src_a, alu_src_b, imm_src, alu_op, illegal};

  localparam logic [16:0] E_FETCH_IDLE = {5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0};
  localparam logic [16:0] E_FETCH_RDY  = {5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0};
  localparam logic [16:0] E_DECODE     = {5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 1'b0};
  localparam logic [16:0] E_DECODE_ILL = {5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 1'b1};
  localparam logic [16:0] E_MEMADR_LW  = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0};
  localparam logic [16:0] E_MEMADR_SW  = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 1'b0};
  localparam logic [16:0] E_MEMREAD    = {5'b01000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [16:0] E_MEMWB      = {5'b00001, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [16:0] E_MEMWRITE   = {5'b01100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [16:0] E_ALUWB      = {5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [16:0] E_JAL        = {5'b10000, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 1'b0};
  localparam logic [16:0] E_BEQ_T      = {5'b10000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 1'b0};
  localparam logic [16:0] E_BEQ_N      = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 1'b0};

  function automatic logic [16:0] e_exec_r(input logic [2:0] op);
    return {5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, op, 1'b0};
  endfunction

  function automatic logic [16:0] e_exec_i(input logic [2:0] op);
    return {5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, op, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7);
    opcode   = opc;
    funct3   = f3;
    funct7b5 = f7;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0;
    set_instr(7'b1100011, 3'b000, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    assert_count++;
    if (outs !== E_FETCH_IDLE) begin
      fail_count++; $display("FAIL reset_fetch: got %b expected %b", outs, E_FETCH_IDLE);
    end
    // Walk into BEQ, then hold reset two cycles
    mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    #1;
    assert_count++;
    if (outs !== E_BEQ_N) begin
      fail_count++; $display("FAIL reset_pre_beq: got %b expected %b", outs, E_BEQ_N);
    end
    rst_n = 1'b0;
    tick(); tick();
    assert_count++;
    if (outs !== E_FETCH_IDLE || mem_write !== 1'b0 || reg_write !== 1'b0) begin
      fail_count++; $display("FAIL reset_from_beq: got %b expected %b", outs, E_FETCH_IDLE);
    end
    rst_n = 1'b1;
    // Reset arriving in MEMWRITE must drop the store strobe at once
    set_instr(7'b0100011, 3'b010, 1'b0);
    mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    assert_count++;
    if (outs !== E_MEMWRITE) begin
      fail_count++; $display("FAIL reset_pre_memwrite: got %b expected %b", outs, E_MEMWRITE);
    end
    rst_n = 1'b0;
    #1;
    assert_count++;
    if (mem_write !== 1'b0) begin
      fail_count++; $display("FAIL reset_drop_mem_write: got %b expected 0", mem_write);
    end
    tick();
    rst_n = 1'b1;
    #1;
    assert_count++;
    if (outs !== E_FETCH_IDLE) begin
      fail_count++; $display("FAIL reset_from_memwrite: got %b expected %b", outs, E_FETCH_IDLE);
    end
  endtask

  task automatic test_rtype_add();
    logic [16:0] exp [4];
    exp = '{E_FETCH_RDY, E_DECODE, e_exec_r(3'b000), E_ALUWB};
    set_instr(7'b0110011, 3'b000, 1'b0);   // add x3,x1,x2 = 0x002081B3
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      assert_count++;
      if (outs !== exp[i]) begin
        fail_count++; $display("FAIL add cyc%0d: got %b expected %b", i, outs, exp[i]);
      end
      tick();
    end
    assert_count++;
    if (outs !== E_FETCH_RDY) begin
      fail_count++; $display("FAIL add_return: got %b expected %b", outs, E_FETCH_RDY);
    end
  endtask

  task automatic test_sub_addi();
    logic [16:0] exp [2][4];
    exp[0] = '{E_FETCH_RDY, E_DECODE, e_exec_r(3'b001), E_ALUWB};
    exp[1] = '{E_FETCH_RDY, E_DECODE, e_exec_i(3'b000), E_ALUWB};
    mem_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) set_instr(7'b0110011, 3'b000, 1'b1);
      else        set_instr(7'b0010011, 3'b000, 1'b1);
      for (int i = 0; i < 4; i++) begin
        #1;
        assert_count++;
        if (outs !== exp[t][i]) begin
          fail_count++;
          $display("FAIL %s cyc%0d: got %b expected %b", (t == 0) ? "sub" : "addi", i, outs, exp[t][i]);
        end
        tick();
      end
    end
  endtask

  task automatic test_alu_ops();
    // {opcode R?, funct3, funct7b5, expected alu_op}
    logic       is_r [9];
    logic [2:0] f3   [9];
    logic       f7   [9];
    logic [2:0] eop  [9];
    is_r = '{1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b0,   1'b0};
    f3   = '{3'b111, 3'b110, 3'b100, 3'b010, 3'b001, 3'b101, 3'b101, 3'b011, 3'b111};
    f7   = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b1,   1'b0,   1'b1};
    eop  = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b111, 3'b000, 3'b010};
    mem_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      set_instr(is_r[k] ? 7'b0110011 : 7'b0010011, f3[k], f7[k]);
      tick(); tick();
      assert_count++;
      if (outs !== (is_r[k] ? e_exec_r(eop[k]) : e_exec_i(eop[k]))) begin
        fail_count++;
        $display("FAIL alu_op[%0d] f3=%b: got %b expected alu_op %b", k, f3[k], outs, eop[k]);
      end
      tick(); tick();
    end
  endtask

  task automatic test_lw_stall();
    logic [16:0] exp [10];
    logic        rdy [10];
    exp = '{E_FETCH_RDY, E_DECODE, E_MEMADR_LW, E_MEMREAD, E_MEMREAD, E_MEMREAD,
            E_MEMREAD, E_MEMWB, E_FETCH_IDLE, E_FETCH_IDLE};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    set_instr(7'b0000011, 3'b010, 1'b0);
    for (int i = 0; i < 10; i++) begin
      mem_ready = rdy[i];
      #1;
      assert_count++;
      if (outs !== exp[i]) begin
        fail_count++; $display("FAIL lw cyc%0d: got %b expected %b", i, outs, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_sw();
    logic [16:0] exp [5];
    logic        rdy [5];
    exp = '{E_FETCH_RDY, E_DECODE, E_MEMADR_SW, E_MEMWRITE, E_MEMWRITE};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    set_instr(7'b0100011, 3'b010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i];
      #1;
      assert_count++;
      if (outs !== exp[i]) begin
        fail_count++; $display("FAIL sw cyc%0d: got %b expected %b", i, outs, exp[i]);
      end
      tick();
    end
    mem_ready = 1'b0;
    #1;
    assert_count++;
    if (outs !== E_FETCH_IDLE) begin
      fail_count++; $display("FAIL sw_return: got %b expected %b", outs, E_FETCH_IDLE);
    end
  endtask

  task automatic test_jal();
    logic [16:0] exp [4];
    exp = '{E_FETCH_RDY, E_DECODE, E_JAL, E_ALUWB};
    set_instr(7'b1101111, 3'b000, 1'b0);
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      assert_count++;
      if (outs !== exp[i]) begin
        fail_count++; $display("FAIL jal cyc%0d: got %b expected %b", i, outs, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_beq();
    set_instr(7'b1100011, 3'b000, 1'b0);
    for (int t = 0; t < 2; t++) begin
      zero      = (t == 0);
      mem_ready = 1'b1;
      tick(); tick();
      assert_count++;
      if (outs !== ((t == 0) ? E_BEQ_T : E_BEQ_N)) begin
        fail_count++;
        $display("FAIL beq zero=%0b: got %b expected %b", zero, outs, (t == 0) ? E_BEQ_T : E_BEQ_N);
      end
      mem_ready = 1'b0;
      tick();
      assert_count++;
      if (outs !== E_FETCH_IDLE) begin
        fail_count++; $display("FAIL beq_return zero=%0b: got %b expected %b", zero, outs, E_FETCH_IDLE);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal();
    logic [16:0] exp [3];
    logic        rdy [3];
    exp = '{E_FETCH_RDY, E_DECODE_ILL, E_FETCH_IDLE};
    rdy = '{1'b1, 1'b0, 1'b0};
    set_instr(7'h7F, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      mem_ready = rdy[i];
      #1;
      assert_count++;
      if (outs !== exp[i]) begin
        fail_count++; $display("FAIL illegal cyc%0d: got %b expected %b", i, outs, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    // jal then add, memory always ready: 4 + 4 cycles, then FETCH again
    logic [16:0] exp [9];
    exp = '{E_FETCH_RDY, E_DECODE, E_JAL, E_ALUWB,
            E_FETCH_RDY, E_DECODE, e_exec_r(3'b000), E_ALUWB, E_FETCH_RDY};
    mem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 4) set_instr(7'b1101111, 3'b000, 1'b0);
      else       set_instr(7'b0110011, 3'b000, 1'b0);
      #1;
      assert_count++;
      if (outs !== exp[i]) begin
        fail_count++; $display("FAIL b2b cyc%0d: got %b expected %b", i, outs, exp[i]);
      end
      tick();
    end
    mem_ready = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_rtype_add();
    test_sub_addi();
    test_alu_ops();
    test_lw_stall();
    test_sw();
    test_jal();
    test_beq();
    test_illegal();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
